cnn_frame_sequencer: RTL and testbench

Frame-level controller for the 5x5 CNN AXI-stream core. On a start pulse it reads one IMG_W x IMG_H frame of 8-bit pixels from a pixel RAM and streams them into the core's slave AXI-stream, honouring backpressure. It collects the core's result words from the core's master stream into a result RAM, then signals done. It replaces bench-style ad-hoc pixel feeding with a reusable, backpressure-safe sequencer.

---
 rtl/cnn_frame_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_cnn_frame_sequencer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer for the 5x5 CNN AXI-stream core: streams one pixel
// frame from RAM into the core and collects its result words.
module cnn_frame_sequencer #(
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int PIX_W     = 8,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int RES_COUNT = 10,
    parameter int RES_AW    = 4
) (
    input  logic                  axis_aclk,
    input  logic                  axis_reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           frame_count,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_rd_addr,
    input  logic [PIX_W-1:0]      mem_rd_data,
    output logic                  m00_axis_tvalid,
    output logic [DATA_W-1:0]     m00_axis_tdata,
    output logic [DATA_W/8-1:0]   m00_axis_tstrb,
    output logic                  m00_axis_tlast,
    input  logic                  m00_axis_tready,
    input  logic                  s00_axis_tvalid,
    input  logic [DATA_W-1:0]     s00_axis_tdata,
    input  logic                  s00_axis_tlast,
    output logic                  s00_axis_tready,
    output logic                  res_wr_en,
    output logic [RES_AW-1:0]     res_wr_addr,
    output logic [DATA_W-1:0]     res_wr_data
);

    localparam int N  = IMG_W * IMG_H;
    localparam int CW = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]     rd_addr;
    logic [CW-1:0]     tx_idx;
    logic              in_flight;
    logic              out_valid;
    logic              skid_valid;
    logic [PIX_W-1:0]  out_data;
    logic [PIX_W-1:0]  skid_data;
    logic              res_open;
    logic [RES_AW-1:0] res_idx;
    logic              err_q;
    logic [15:0]       frame_cnt;

    logic       start_acc;
    logic       pop;
    logic [1:0] occ;
    logic       rd_issue;
    logic       res_hs;
    logic       res_last_beat;
    logic       res_close;
    logic       pix_fin;
    logic       res_fin;

    assign start_acc = (state == IDLE) && start;
    assign pop       = out_valid && m00_axis_tready;

    // Occupancy seen by the next read: held words plus the returning one,
    // minus the word leaving this cycle.
    assign occ = {1'b0, out_valid} + {1'b0, skid_valid}
               + {1'b0, in_flight} - {1'b0, pop};

    assign rd_issue = (state == RUN) && (rd_addr < CW'(N)) && (occ < 2'd2);

    assign res_hs        = s00_axis_tvalid && s00_axis_tready;
    assign res_last_beat = (res_idx == RES_AW'(RES_COUNT - 1));
    assign res_close     = res_hs && (s00_axis_tlast || res_last_beat);

    // Count this cycle's handshakes so coincident final beats finish at once.
    assign pix_fin = (tx_idx == CW'(N)) || (pop && (tx_idx == CW'(N - 1)));
    assign res_fin = !res_open || res_close;

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (pix_fin && res_fin) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy            = 1'b0;
        done            = 1'b0;
        s00_axis_tready = 1'b0;
        unique case (state)
            IDLE: begin
            end
            RUN: begin
                busy            = 1'b1;
                s00_axis_tready = res_open;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            rd_addr    <= '0;
            tx_idx     <= '0;
            in_flight  <= 1'b0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
            res_open   <= 1'b0;
            res_idx    <= '0;
            err_q      <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            in_flight <= rd_issue;
            if (rd_issue) rd_addr <= rd_addr + 1'b1;
            if (pop)      tx_idx  <= tx_idx + 1'b1;

            if (pop) begin
                if (skid_valid) begin
                    out_data   <= skid_data;
                    skid_valid <= in_flight;
                    if (in_flight) skid_data <= mem_rd_data;
                end else begin
                    out_valid <= in_flight;
                    if (in_flight) out_data <= mem_rd_data;
                end
            end else if (in_flight) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= mem_rd_data;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= mem_rd_data;
                end
            end

            if (res_hs)    res_idx  <= res_idx + 1'b1;
            if (res_close) res_open <= 1'b0;
            // Early tlast, or missing tlast on the final expected word.
            if (res_hs && (s00_axis_tlast ^ res_last_beat)) err_q <= 1'b1;

            if ((state == RUN) && (state_nx == DONE)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            if (start_acc) begin
                rd_addr  <= '0;
                tx_idx   <= '0;
                res_idx  <= '0;
                res_open <= 1'b1;
                err_q    <= 1'b0;
            end
        end
    end

    assign err         = err_q;
    assign frame_count = frame_cnt;

    assign mem_rd_en   = rd_issue;
    assign mem_rd_addr = rd_issue ? rd_addr[ADDR_W-1:0] : '0;

    assign m00_axis_tvalid = out_valid;
    assign m00_axis_tdata  = {{(DATA_W - PIX_W){1'b0}}, out_data};
    assign m00_axis_tstrb  = '1;
    assign m00_axis_tlast  = out_valid && (tx_idx == CW'(N - 1));

    assign res_wr_en   = res_hs;
    assign res_wr_addr = res_hs ? res_idx : '0;
    assign res_wr_data = res_hs ? s00_axis_tdata : '0;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Self-checking bench for cnn_frame_sequencer: RAM model, randomized
// backpressure and result traffic, checked against expected frame behaviour.
module tb_cnn_frame_sequencer;

    localparam int N  = 784;
    localparam int RC = 10;

    logic        clk = 1'b0;
    logic        axis_reset;
    logic        start;
    logic        busy, done, err;
    logic [15:0] frame_count;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [7:0]  mem_rd_data;
    logic        m00_axis_tvalid;
    logic [31:0] m00_axis_tdata;
    logic [3:0]  m00_axis_tstrb;
    logic        m00_axis_tlast;
    logic        m00_axis_tready;
    logic        s00_axis_tvalid;
    logic [31:0] s00_axis_tdata;
    logic        s00_axis_tlast;
    logic        s00_axis_tready;
    logic        res_wr_en;
    logic [3:0]  res_wr_addr;
    logic [31:0] res_wr_data;

    always #5 clk = ~clk;

    cnn_frame_sequencer dut (
        .axis_aclk       (clk),
        .axis_reset      (axis_reset),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .frame_count     (frame_count),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tstrb  (m00_axis_tstrb),
        .m00_axis_tlast  (m00_axis_tlast),
        .m00_axis_tready (m00_axis_tready),
        .s00_axis_tvalid (s00_axis_tvalid),
        .s00_axis_tdata  (s00_axis_tdata),
        .s00_axis_tlast  (s00_axis_tlast),
        .s00_axis_tready (s00_axis_tready),
        .res_wr_en       (res_wr_en),
        .res_wr_addr     (res_wr_addr),
        .res_wr_data     (res_wr_data)
    );

    // Pixel RAM with one-cycle read latency
    logic [7:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int fc_exp   = 0;

    logic [31:0] pix_q[$];
    logic        last_q[$];
    int          pix_cyc_q[$];
    int          rd_q[$];
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          first_rd, first_tv, done_cnt, done_cyc;
    int          max_out, stall_viol, rdy_late;
    bit          timed_out;
    logic        busy_after, err_end;
    logic [15:0] fc_after;

    // mode: 0 ready, 1 stall window then alternate, 2 random
    task automatic run_frame(input int mode, input int rn, input int rt,
                             input int rs, input int rp,
                             input logic [31:0] rb, input int sa,
                             input int ab);
        int ridx;
        bit rhold, pstall, rclosed;
        logic [31:0] pd;
        logic pl;
        int outst;
        pix_q.delete(); last_q.delete(); pix_cyc_q.delete(); rd_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        first_rd = -1; first_tv = -1; done_cnt = 0; done_cyc = -10;
        max_out = 0; stall_viol = 0; rdy_late = 0; timed_out = 1'b1;
        busy_after = 1'bx; err_end = 1'bx; fc_after = 'x;
        ridx = 0; rhold = 0; pstall = 0; rclosed = 0; pd = '0; pl = 1'b0;
        for (int c = 0; c < 4 * N + 200; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0) || (c == sa);
            axis_reset = (ab >= 0) && (pix_q.size() >= ab);
            case (mode)
                0:       m00_axis_tready = 1'b1;
                1:       m00_axis_tready = (c >= 10 && c <= 14) ? 1'b0 : (c < 10) ? 1'b1 : (c % 2 == 1);
                default: m00_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
            if (ridx < rn && c >= rs) begin
                if (!rhold) s00_axis_tvalid = ($urandom_range(0, 99) < rp);
            end else begin
                s00_axis_tvalid = 1'b0;
            end
            s00_axis_tdata = rb + 32'(ridx);
            s00_axis_tlast = (ridx == rt);
            if (axis_reset) begin
                timed_out = 1'b0;
                break;
            end
            #1;
            if (mem_rd_en) begin
                rd_q.push_back(int'(mem_rd_addr));
                if (first_rd < 0) first_rd = c;
            end
            if (m00_axis_tvalid && first_tv < 0) first_tv = c;
            if (pstall && (!m00_axis_tvalid || m00_axis_tdata !== pd || m00_axis_tlast !== pl))
                stall_viol++;
            pstall = m00_axis_tvalid && !m00_axis_tready;
            pd = m00_axis_tdata;
            pl = m00_axis_tlast;
            if (m00_axis_tvalid && m00_axis_tready) begin
                pix_q.push_back(m00_axis_tdata);
                last_q.push_back(m00_axis_tlast);
                pix_cyc_q.push_back(c);
            end
            outst = rd_q.size() - pix_q.size();
            if (outst > max_out) max_out = outst;
            if (s00_axis_tready && rclosed) rdy_late++;
            if (s00_axis_tvalid && s00_axis_tready) begin
                if (ridx == rt || ridx == RC - 1) rclosed = 1;
                ridx++;
                rhold = 0;
            end else begin
                rhold = s00_axis_tvalid;
            end
            if (res_wr_en) begin
                wr_addr_q.push_back(int'(res_wr_addr));
                wr_data_q.push_back(res_wr_data);
                wr_cyc_q.push_back(c);
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c == done_cyc + 1) begin
                busy_after = busy;
                err_end = err;
                fc_after = frame_count;
            end
            if (c == done_cyc + 3) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast = 1'b0;
        m00_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        int rd_seen;
        axis_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 axis_reset = 1'b0;
        @(posedge clk);
        #2;
        n_checks++;
        if ({busy, done, err, mem_rd_en, m00_axis_tvalid, m00_axis_tlast, s00_axis_tready, res_wr_en} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000000",
                     {busy, done, err, mem_rd_en, m00_axis_tvalid, m00_axis_tlast, s00_axis_tready, res_wr_en});
        end
        n_checks++;
        if (frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_frame_count: got %0d required 0", frame_count);
        end
        n_checks++;
        if (m00_axis_tstrb !== 4'hF || m00_axis_tdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_tstrb_tdata: got %h/%h required f/0", m00_axis_tstrb, m00_axis_tdata);
        end
        rd_seen = 0;
        repeat (5) begin
            @(posedge clk);
            #2;
            if (mem_rd_en) rd_seen++;
        end
        n_checks++;
        if (rd_seen !== 0) begin
            n_fail++;
            $display("FAIL idle_no_read: got %0d reads required 0", rd_seen);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 1024; i++) ram[i] = 8'(i % 256);
        run_frame(0, RC, RC - 1, 1, 50, 32'h10, -1, -1);
        fc_exp = (fc_exp + 1) % 65536;
        n_checks++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL stream_timeout: got no done required done");
        end
        n_checks++;
        if (first_rd !== 1 || first_tv !== 3) begin
            n_fail++;
            $display("FAIL stream_latency: got rd %0d tvalid %0d required 1 3", first_rd, first_tv);
        end
        n_checks++;
        if (pix_q.size() !== N) begin
            n_fail++;
            $display("FAIL stream_beats: got %0d required %0d", pix_q.size(), N);
        end
        for (int i = 0; i < pix_q.size(); i++) begin
            n_checks++;
            if (pix_q[i] !== 32'(i % 256) || last_q[i] !== (i == N - 1) || pix_cyc_q[i] !== 3 + i) begin
                n_fail++;
                $display("FAIL stream_beat%0d: got %h last %b cyc %0d required %h last %b cyc %0d",
                         i, pix_q[i], last_q[i], pix_cyc_q[i], 32'(i % 256), (i == N - 1), 3 + i);
                break;
            end
        end
        n_checks++;
        if (done_cnt !== 1 || fc_after !== 16'(fc_exp)) begin
            n_fail++;
            $display("FAIL stream_done: got pulses %0d count %0d required 1 %0d", done_cnt, fc_after, fc_exp);
        end
    endtask

    task automatic test_backpressure();
        for (int m = 1; m <= 2; m++) begin
            for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
            run_frame(m, RC, RC - 1, 1, 40, 32'h20, -1, -1);
            fc_exp = (fc_exp + 1) % 65536;
            n_checks++;
            if (timed_out || pix_q.size() !== N) begin
                n_fail++;
                $display("FAIL bp%0d_beats: got %0d required %0d", m, pix_q.size(), N);
            end
            for (int i = 0; i < pix_q.size(); i++) begin
                n_checks++;
                if (pix_q[i] !== {24'h0, ram[i]} || last_q[i] !== (i == N - 1)) begin
                    n_fail++;
                    $display("FAIL bp%0d_beat%0d: got %h last %b required %h last %b",
                             m, i, pix_q[i], last_q[i], {24'h0, ram[i]}, (i == N - 1));
                    break;
                end
            end
            n_checks++;
            if (stall_viol !== 0) begin
                n_fail++;
                $display("FAIL bp%0d_stall_stable: got %0d changes required 0", m, stall_viol);
            end
            n_checks++;
            if (max_out > 3) begin
                n_fail++;
                $display("FAIL bp%0d_occupancy: got %0d required <=3", m, max_out);
            end
            n_checks++;
            if (rd_q.size() !== N) begin
                n_fail++;
                $display("FAIL bp%0d_reads: got %0d required %0d", m, rd_q.size(), N);
            end
        end
    endtask

    task automatic test_results();
        int exp_done;
        run_frame(2, RC, RC - 1, 1, 30, 32'hA0, -1, -1);
        fc_exp = (fc_exp + 1) % 65536;
        n_checks++;
        if (wr_addr_q.size() !== RC) begin
            n_fail++;
            $display("FAIL res_count: got %0d required %0d", wr_addr_q.size(), RC);
        end
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            n_checks++;
            if (wr_addr_q[i] !== i || wr_data_q[i] !== 32'hA0 + 32'(i)) begin
                n_fail++;
                $display("FAIL res_write%0d: got %0d/%h required %0d/%h",
                         i, wr_addr_q[i], wr_data_q[i], i, 32'hA0 + 32'(i));
            end
        end
        n_checks++;
        if (done_cnt !== 1 || err_end !== 1'b0 || busy_after !== 1'b0 || fc_after !== 16'(fc_exp)) begin
            n_fail++;
            $display("FAIL res_done: got pulses %0d err %b busy %b count %0d required 1 0 0 %0d",
                     done_cnt, err_end, busy_after, fc_after, fc_exp);
        end
        exp_done = pix_cyc_q.size() > 0 ? pix_cyc_q[$] : 0;
        if (wr_cyc_q.size() > 0 && wr_cyc_q[$] > exp_done) exp_done = wr_cyc_q[$];
        n_checks++;
        if (done_cyc !== exp_done + 1) begin
            n_fail++;
            $display("FAIL res_done_cycle: got %0d required %0d", done_cyc, exp_done + 1);
        end
    endtask

    task automatic test_err();
        run_frame(0, RC, 7, 1, 60, 32'h300, -1, -1);
        fc_exp = (fc_exp + 1) % 65536;
        n_checks++;
        if (wr_addr_q.size() !== 8 || err_end !== 1'b1 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL err_early_tlast: got writes %0d err %b done %0d required 8 1 1",
                     wr_addr_q.size(), err_end, done_cnt);
        end
        run_frame(0, RC + 2, -1, 1, 60, 32'h400, -1, -1);
        fc_exp = (fc_exp + 1) % 65536;
        n_checks++;
        if (wr_addr_q.size() !== RC || err_end !== 1'b1 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL err_no_tlast: got writes %0d err %b done %0d required %0d 1 1",
                     wr_addr_q.size(), err_end, done_cnt, RC);
        end
        n_checks++;
        if (rdy_late !== 0) begin
            n_fail++;
            $display("FAIL err_ready_after_close: got %0d cycles required 0", rdy_late);
        end
        run_frame(0, RC, RC - 1, 1, 60, 32'h500, -1, -1);
        fc_exp = (fc_exp + 1) % 65536;
        n_checks++;
        if (err_end !== 1'b0 || fc_after !== 16'(fc_exp)) begin
            n_fail++;
            $display("FAIL err_cleared: got err %b count %0d required 0 %0d", err_end, fc_after, fc_exp);
        end
    endtask

    task automatic test_simultaneous();
        run_frame(0, RC, RC - 1, N - 7, 100, 32'h600, -1, -1);
        fc_exp = (fc_exp + 1) % 65536;
        n_checks++;
        if (wr_cyc_q.size() !== RC || pix_cyc_q.size() !== N) begin
            n_fail++;
            $display("FAIL simul_counts: got %0d/%0d required %0d/%0d",
                     wr_cyc_q.size(), pix_cyc_q.size(), RC, N);
        end else begin
            n_checks++;
            if (wr_cyc_q[$] !== N + 2 || pix_cyc_q[$] !== N + 2) begin
                n_fail++;
                $display("FAIL simul_final_cycles: got res %0d pix %0d required %0d",
                         wr_cyc_q[$], pix_cyc_q[$], N + 2);
            end
        end
        n_checks++;
        if (done_cyc !== N + 3 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL simul_done: got cycle %0d pulses %0d required %0d 1", done_cyc, done_cnt, N + 3);
        end
    endtask

    task automatic test_abort();
        int bad_seq;
        int done_seen;
        run_frame(2, RC, RC - 1, 1, 50, 32'h700, 50, -1);
        fc_exp = (fc_exp + 1) % 65536;
        bad_seq = 0;
        for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] != i) bad_seq++;
        n_checks++;
        if (rd_q.size() !== N || bad_seq !== 0 || pix_q.size() !== N || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL start_ignored: got reads %0d bad %0d beats %0d done %0d required %0d 0 %0d 1",
                     rd_q.size(), bad_seq, pix_q.size(), done_cnt, N, N);
        end
        run_frame(0, RC, RC - 1, 1, 50, 32'h800, -1, 400);
        @(posedge clk);
        #2;
        fc_exp = 0;
        n_checks++;
        if ({busy, done, err, mem_rd_en, m00_axis_tvalid, s00_axis_tready, res_wr_en} !== 7'h00 ||
            frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_clear: got %b count %0d required 0000000 0",
                     {busy, done, err, mem_rd_en, m00_axis_tvalid, s00_axis_tready, res_wr_en}, frame_count);
        end
        done_seen = 0;
        repeat (2) begin
            @(posedge clk);
            #2;
            if (done) done_seen++;
        end
        #1 axis_reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #2;
            if (done) done_seen++;
        end
        n_checks++;
        if (done_seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d pulses required 0", done_seen);
        end
        run_frame(0, RC, RC - 1, 1, 50, 32'h900, -1, -1);
        fc_exp = (fc_exp + 1) % 65536;
        n_checks++;
        if (rd_q.size() === 0 || rd_q[0] !== 0 || first_rd !== 1) begin
            n_fail++;
            $display("FAIL restart_addr: got first read cycle %0d required addr 0 at cycle 1", first_rd);
        end
        n_checks++;
        if (pix_q.size() !== N || pix_q[0] !== {24'h0, ram[0]} || fc_after !== 16'(fc_exp)) begin
            n_fail++;
            $display("FAIL restart_frame: got beats %0d count %0d required %0d %0d",
                     pix_q.size(), fc_after, N, fc_exp);
        end
    endtask

    initial begin
        axis_reset = 1'b1;
        start = 1'b0;
        m00_axis_tready = 1'b0;
        s00_axis_tvalid = 1'b0;
        s00_axis_tdata = '0;
        s00_axis_tlast = 1'b0;
        for (int i = 0; i < 1024; i++) ram[i] = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_results();
        test_err();
        test_simultaneous();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
